// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: load-use stall, branch flush, imem bubbles, multi-cycle EX FSM.
// Optional perf counters (stall_cycles, flush_count) are enabled by defining HAZ_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1d,
    input  logic [REG_AW-1:0] rs2d,
    input  logic [REG_AW-1:0] rs1e,
    input  logic [REG_AW-1:0] rs2e,
    input  logic [REG_AW-1:0] rde,
    input  logic              regwrite_e,
    input  logic              memread_e,
    input  logic [REG_AW-1:0] rdm,
    input  logic [REG_AW-1:0] rdw,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    input  logic              pcsrc_e,
    input  logic              mc_start_e,
    input  logic              mc_done,
    input  logic              imem_ready,
    output logic              stallf,
    output logic              fede_en_n,
    output logic              fede_clr,
    output logic              deex_en_n,
    output logic              deex_clr,
    output logic              exmem_clr,
    output logic [1:0]        fwda_e,
    output logic [1:0]        fwdb_e,
    output logic              mc_err,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    typedef enum logic [1:0] {RUN, MC_WAIT, ERR} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] mc_cnt;
    logic             load_use, mc_stall, flush;

    assign load_use = memread_e & regwrite_e & (rde != '0) & ((rde == rs1d) | (rde == rs2d));
    assign mc_stall = ((state == MC_WAIT) | ((state == RUN) & mc_start_e)) & ~mc_done;
    assign flush    = rst_n & (state != ERR) & ~mc_stall & pcsrc_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            mc_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == RUN && state_nxt == MC_WAIT)
                mc_cnt <= '0;
            else if (state == MC_WAIT && mc_cnt != '1)
                mc_cnt <= mc_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (mc_start_e && !mc_done) state_nxt = MC_WAIT;
            MC_WAIT: if (mc_done) state_nxt = RUN;
                     else if (mc_cnt == CNT_W'(MC_TIMEOUT - 1)) state_nxt = ERR;
            ERR:     state_nxt = ERR;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        stallf    = 1'b0;
        fede_en_n = 1'b0;
        fede_clr  = 1'b0;
        deex_en_n = 1'b0;
        deex_clr  = 1'b0;
        exmem_clr = 1'b0;
        mc_err    = 1'b0;
        if (!rst_n) begin
            fede_clr  = 1'b1;
            deex_clr  = 1'b1;
            exmem_clr = 1'b1;
        end else if (state == ERR) begin
            stallf    = 1'b1;
            fede_en_n = 1'b1;
            deex_en_n = 1'b1;
            exmem_clr = 1'b1;
            mc_err    = 1'b1;
        end else if (mc_stall) begin
            stallf    = 1'b1;
            fede_en_n = 1'b1;
            deex_en_n = 1'b1;
            exmem_clr = 1'b1;
        end else if (flush) begin
            fede_clr = 1'b1;
            deex_clr = 1'b1;
        end else if (load_use) begin
            // Imem wait folds in here: fede is already held, so it must not be cleared.
            stallf    = 1'b1;
            fede_en_n = 1'b1;
            deex_clr  = 1'b1;
        end else if (!imem_ready) begin
            stallf   = 1'b1;
            fede_clr = 1'b1;
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (regwrite_m && rdm != '0 && rdm == rs)      return 2'b10;
        else if (regwrite_w && rdw != '0 && rdw == rs) return 2'b01;
        else                                           return 2'b00;
    endfunction

    assign fwda_e = fwd_sel(rs1e);
    assign fwdb_e = fwd_sel(rs2e);

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stallf) stall_cycles <= stall_cycles + 1'b1;
            if (flush)  flush_count  <= flush_count + 1'b1;
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MC_TIMEOUT=8); perf expectations follow HAZ_PERF_CNT_EN.
module tb_hazard_ctrl;
    localparam int AW = 5;
    localparam int CW = 32;

    // {stallf, fede_en_n, fede_clr, deex_en_n, deex_clr, exmem_clr, mc_err}
    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_RST  = 7'b0010110;
    localparam logic [6:0] C_LU   = 7'b1100100;
    localparam logic [6:0] C_BR   = 7'b0010100;
    localparam logic [6:0] C_MC   = 7'b1101010;
    localparam logic [6:0] C_ERR  = 7'b1101011;
    localparam logic [6:0] C_IM   = 7'b1010000;

    logic clk = 1'b0, rst_n;
    logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic regwrite_e, memread_e, regwrite_m, regwrite_w, pcsrc_e, mc_start_e, mc_done, imem_ready;
    logic stallf, fede_en_n, fede_clr, deex_en_n, deex_clr, exmem_clr, mc_err;
    logic [1:0] fwda_e, fwdb_e;
    logic [CW-1:0] stall_cycles, flush_count;
    logic [6:0] ctl;

    int checks = 0, failures = 0;
    int exp_stall = 0, exp_flush = 0;
    logic [6:0] last_exp = C_IDLE;

    hazard_ctrl #(.REG_AW(AW), .MC_TIMEOUT(8), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e), .rde(rde),
        .regwrite_e(regwrite_e), .memread_e(memread_e),
        .rdm(rdm), .rdw(rdw), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .pcsrc_e(pcsrc_e), .mc_start_e(mc_start_e), .mc_done(mc_done), .imem_ready(imem_ready),
        .stallf(stallf), .fede_en_n(fede_en_n), .fede_clr(fede_clr),
        .deex_en_n(deex_en_n), .deex_clr(deex_clr), .exmem_clr(exmem_clr),
        .fwda_e(fwda_e), .fwdb_e(fwdb_e), .mc_err(mc_err),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;
    assign ctl = {stallf, fede_en_n, fede_clr, deex_en_n, deex_clr, exmem_clr, mc_err};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        chk(tag, {25'b0, ctl}, {25'b0, exp});
        last_exp = exp;
    endtask

    // Counter model: stall counts cycles with stallf expected, flush counts branch-pattern cycles.
    task automatic cyc();
        if (rst_n && last_exp[6]) exp_stall++;
        if (rst_n && last_exp == C_BR) exp_flush++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_perf(input string tag);
`ifdef HAZ_PERF_CNT_EN
        chk({tag, "_stall"}, stall_cycles, exp_stall);
        chk({tag, "_flush"}, flush_count, exp_flush);
`else
        chk({tag, "_stall"}, stall_cycles, 0);
        chk({tag, "_flush"}, flush_count, 0);
`endif
    endtask

    task automatic idle_inputs();
        {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw} = '0;
        {regwrite_e, memread_e, regwrite_m, regwrite_w, pcsrc_e, mc_start_e, mc_done} = '0;
        imem_ready = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk_ctl("reset_ctl", C_RST);
        chk_perf("reset");
        cyc(); cyc();
        rst_n = 1'b1;
        #1;
        chk_ctl("idle", C_IDLE);
        cyc();

        // Load-use on rs1d, then on rs2d, then x0 never hazards
        memread_e = 1; regwrite_e = 1; rde = 5; rs1d = 5; #1;
        chk_ctl("lu_rs1", C_LU);
        cyc();
        memread_e = 0; #1;
        chk_ctl("lu_release", C_IDLE);
        cyc();
        memread_e = 1; rs1d = 0; rs2d = 5; #1;
        chk_ctl("lu_rs2", C_LU);
        rde = 0; rs2d = 0; #1;
        chk_ctl("lu_x0", C_IDLE);
        rde = 5; rs2d = 5;

        // Branch suppresses load-use
        pcsrc_e = 1; #1;
        chk_ctl("br_lu", C_BR);
        cyc();
        idle_inputs(); #1;
        chk_ctl("br_after", C_IDLE);
        chk_perf("lu_br");
        cyc();

        // Multi-cycle op: start cycle + 3 wait cycles stalled, released by mc_done
        mc_start_e = 1; #1;
        chk_ctl("mc_start", C_MC);
        cyc();
        for (int i = 0; i < 3; i++) begin
            pcsrc_e = (i == 1); #1;
            chk_ctl($sformatf("mc_wait%0d", i), C_MC);
            cyc();
        end
        pcsrc_e = 0; mc_done = 1; #1;
        chk_ctl("mc_done", C_IDLE);
        cyc();
        mc_start_e = 0; mc_done = 0; #1;
        chk_ctl("mc_back_run", C_IDLE);
        cyc();
        mc_start_e = 1; mc_done = 1; #1;
        chk_ctl("mc_same_cycle", C_IDLE);
        cyc();
        mc_start_e = 0; mc_done = 0; #1;
        chk_ctl("mc_same_run", C_IDLE);
        cyc();

        // Timeout: start cycle + 8 MC_WAIT cycles, then ERR
        mc_start_e = 1; #1;
        chk_ctl("to_start", C_MC);
        cyc();
        for (int i = 0; i < 8; i++) begin
            #1;
            chk_ctl($sformatf("to_wait%0d", i), C_MC);
            cyc();
        end
        mc_start_e = 0; #1;
        chk_ctl("to_err", C_ERR);
        cyc();
        mc_done = 1; pcsrc_e = 1; #1;
        chk_ctl("err_sticky", C_ERR);
        chk_perf("err");
        cyc();
        rst_n = 0; #1;
        exp_stall = 0; exp_flush = 0;
        chk_ctl("err_reset", C_RST);
        chk_perf("err_reset");
        cyc();
        rst_n = 1; idle_inputs(); #1;
        chk_ctl("err_cleared", C_IDLE);
        cyc();

        // Forwarding priority and x0
        rs1e = 7; rdm = 7; rdw = 7; regwrite_m = 1; regwrite_w = 1; #1;
        chk("fwda_mem", {30'b0, fwda_e}, 2);
        rdm = 0; #1;
        chk("fwda_wb", {30'b0, fwda_e}, 1);
        rs2e = 0; rdw = 0; #1;
        chk("fwdb_x0", {30'b0, fwdb_e}, 0);
        rs2e = 7; rdm = 7; rdw = 7; regwrite_m = 0; #1;
        chk("fwdb_wb_only", {30'b0, fwdb_e}, 1);
        regwrite_w = 0; #1;
        chk("fwdb_none", {30'b0, fwdb_e}, 0);
        idle_inputs();

        // Imem wait, alone and with load-use
        imem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk_ctl($sformatf("imem%0d", i), C_IM);
            cyc();
        end
        memread_e = 1; regwrite_e = 1; rde = 9; rs2d = 9; #1;
        chk_ctl("imem_lu", C_LU);
        cyc();
        pcsrc_e = 1; #1;
        chk_ctl("imem_br", C_BR);
        cyc();
        idle_inputs(); #1;
        chk_ctl("final_idle", C_IDLE);
        chk_perf("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
